minc_seq: RTL and testbench

MINC_SEQ -- requirements
Module: minc_seq

---
 rtl/minc_seq.sv | 160 ++++++++++++++++
 tb/tb_minc_seq.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minc_seq.sv
// minc_seq: fetch/execute sequencer for a tiny 8-bit stack machine.
// The top of stack lives in a register; the rest of the stack is in an external single-port RAM.
module minc_seq #(
  parameter int         MUL_EN  = 1,
  parameter logic [7:0] SP_INIT = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [11:0] imem_data,
  output logic [7:0]  ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  pc_out,
  output logic [7:0]  sp_out,
  output logic [7:0]  top_out,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] OP_PUSH = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h8;

  logic [1:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  sp_q, sp_d;
  logic [7:0]  top_q, top_d;
  logic        halted_q, halted_d;
  logic [11:0] ir_q, ir_d;
  logic        req_q, req_d;

  logic [3:0]  opcode;
  logic [7:0]  imm;
  logic [7:0]  sp_inc;
  logic [7:0]  sp_dec;
  logic        is_binop;
  logic        fetch_req;
  logic [7:0]  alu_res;

  assign opcode   = ir_q[11:8];
  assign imm      = ir_q[7:0];
  assign sp_inc   = sp_q + 8'd1;
  assign sp_dec   = sp_q - 8'd1;
  assign is_binop = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    ((opcode == OP_MUL) && (MUL_EN != 0));

  // NOS arrives on ram_rdata in WB; SUB is NOS minus TOP.
  always_comb begin
    case (opcode)
      OP_ADD:  alu_res = ram_rdata + top_q;
      OP_SUB:  alu_res = ram_rdata - top_q;
      default: alu_res = ram_rdata * top_q;
    endcase
  end

  // imem handshake: once imem_req rises it stays high with imem_addr stable until an
  // edge with imem_ack=1; imem_ack is only honoured on edges where imem_req is high.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sp_d      = sp_q;
    top_d     = top_q;
    halted_d  = halted_q;
    ir_d      = ir_q;
    req_d     = req_q;
    fetch_req = 1'b0;
    ram_addr  = sp_q;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    case (state_q)
      S_FETCH: begin
        fetch_req = run | req_q;
        if (fetch_req) begin
          if (imem_ack) begin
            ir_d    = imem_data;
            req_d   = 1'b0;
            state_d = S_EXEC;
          end else begin
            req_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (opcode == OP_PUSH) begin
          ram_addr  = sp_inc;
          ram_we    = 1'b1;
          ram_wdata = imm;
          sp_d      = sp_inc;
          top_d     = imm;
          pc_d      = pc_q + 8'd1;
          state_d   = S_FETCH;
        end else if (is_binop) begin
          ram_addr = sp_dec;
          state_d  = S_WB;
        end else if (opcode == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          pc_d    = pc_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        ram_addr  = sp_dec;
        ram_we    = 1'b1;
        ram_wdata = alu_res;
        sp_d      = sp_dec;
        top_d     = alu_res;
        pc_d      = pc_q + 8'd1;
        state_d   = S_FETCH;
      end
      default: ;
    endcase
    if (RESET) begin
      fetch_req = 1'b0;
      ram_we    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_FETCH;
      pc_q     <= 8'h00;
      sp_q     <= SP_INIT;
      top_q    <= 8'h00;
      halted_q <= 1'b0;
      ir_q     <= 12'h000;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      top_q    <= top_d;
      halted_q <= halted_d;
      ir_q     <= ir_d;
      req_q    <= req_d;
    end
  end

  assign imem_req  = fetch_req;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign sp_out    = sp_q;
  assign top_out   = top_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_minc_seq.sv
// Bench for minc_seq: fixed program table, hand-built timing corners, and random
// programs checked against an instruction-level stack-machine model.
module tb_minc_seq;

  localparam int         MUL_EN  = 1;
  localparam logic [7:0] SP_INIT = 8'h00;
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WB    = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic        CLK;
  logic        RESET;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [11:0] imem_data;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  pc_out;
  logic [7:0]  sp_out;
  logic [7:0]  top_out;
  logic        halted;
  logic [1:0]  dbg_state;

  minc_seq #(.MUL_EN(MUL_EN), .SP_INIT(SP_INIT)) dut (
    .CLK(CLK), .RESET(RESET), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pc_out(pc_out), .sp_out(sp_out), .top_out(top_out), .halted(halted),
    .dbg_state(dbg_state)
  );

  logic [11:0] imem [256];
  logic [7:0]  ram [256];
  logic [7:0]  model_mem [256];
  logic [15:0] exp_q [$];
  int          n_tests;
  int          n_fail;
  int          req_cnt;
  int          we_cnt;
  logic        last_req;
  logic        last_we;
  logic [7:0]  last_addr;
  bit          sb_on;
  bit          rand_delay;
  bit          spur_ack;
  int          ack_delay;
  logic [7:0]  m_pc, m_sp, m_top;

  typedef struct {
    logic [11:0] i0, i1, i2;
    logic [7:0]  top, sp, ram_sp;
    int          cycles;
  } vec_t;

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- synchronous stack RAM ----------------
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram_rdata = 8'h00;
    forever begin
      @(posedge CLK);
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  // ---------------- instruction memory responder ----------------
  initial begin
    int wait_cnt;
    int tgt;
    bit busy;
    wait_cnt  = 0;
    tgt       = 0;
    busy      = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 12'h000;
    forever begin
      @(negedge CLK);
      if (imem_req) begin
        if (!busy) begin
          busy     = 1'b1;
          wait_cnt = 0;
          tgt      = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
        end
        if (wait_cnt >= tgt) begin
          imem_ack  = 1'b1;
          imem_data = imem[imem_addr];
          busy      = 1'b0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        busy     = 1'b0;
        imem_ack = spur_ack;
        if (spur_ack) imem_data = 12'h0AA;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input logic cond);
    n_tests++;
    if (cond !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got 0 expected 1", name);
    end
  endtask

  // One clock: sample outputs mid-cycle, score RAM writes, then step past the edge.
  task automatic tick();
    logic [15:0] e;
    @(negedge CLK);
    #1;
    last_req  = imem_req;
    last_addr = imem_addr;
    last_we   = ram_we;
    if (imem_req) req_cnt++;
    if (ram_we) we_cnt++;
    if (sb_on && ram_we) begin
      if (exp_q.size() == 0) begin
        check_true("sb_extra_write", 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sb_write", {ram_addr, ram_wdata}, e);
      end
    end
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    run   = 1'b0;
    tick();
    tick();
    RESET   = 1'b0;
    req_cnt = 0;
    we_cnt  = 0;
  endtask

  task automatic run_until_pc(input logic [7:0] target, input int budget, output int cyc);
    cyc = 0;
    while (pc_out !== target && cyc < budget) begin
      tick();
      cyc++;
    end
    if (cyc >= budget) check_true("timeout_pc", 1'b0);
  endtask

  task automatic run_until_halted(input int budget, input bit random_run, output int cyc);
    cyc = 0;
    while (halted !== 1'b1 && cyc < budget) begin
      if (random_run) run = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    if (cyc >= budget) check_true("timeout_halt", 1'b0);
  endtask

  // Instruction-level model: interprets imem from pc 0 until HALT on a RAM copy.
  task automatic model_run();
    logic [3:0] op;
    logic [7:0] im, nos_addr, r;
    int steps;
    m_pc = 8'h00; m_sp = SP_INIT; m_top = 8'h00; steps = 0;
    while (imem[m_pc][11:8] != 4'h8 && steps < 300) begin
      op = imem[m_pc][11:8];
      im = imem[m_pc][7:0];
      if (op == 4'h0) begin
        m_sp = m_sp + 8'd1;
        model_mem[m_sp] = im;
        m_top = im;
        exp_q.push_back({m_sp, im});
      end else if (op == 4'h4 || op == 4'h5 || (op == 4'h6 && MUL_EN != 0)) begin
        nos_addr = m_sp - 8'd1;
        if (op == 4'h4)      r = model_mem[nos_addr] + m_top;
        else if (op == 4'h5) r = model_mem[nos_addr] - m_top;
        else                 r = model_mem[nos_addr] * m_top;
        m_sp = nos_addr;
        model_mem[m_sp] = r;
        m_top = r;
        exp_q.push_back({m_sp, r});
      end
      m_pc = m_pc + 8'd1;
      steps++;
    end
  endtask

  // ---------------- main test sequence ----------------
  initial begin
    vec_t vecs [7];
    int cyc;
    int bad;
    logic [7:0] r0, rff, v1, v2;
    n_tests = 0; n_fail = 0; req_cnt = 0; we_cnt = 0;
    RESET = 1'b1; run = 1'b0; sb_on = 1'b0; rand_delay = 1'b0; spur_ack = 1'b0; ack_delay = 0;
    last_req = 1'b0; last_we = 1'b0; last_addr = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = 12'h800;

    // reset: run high while RESET held must not fetch
    run = 1'b1;
    tick();
    check("reset_req", last_req, 1'b0);
    check("reset_we", last_we, 1'b0);
    tick();
    RESET = 1'b0; run = 1'b0;
    check("reset_pc", pc_out, 8'h00);
    check("reset_sp", sp_out, SP_INIT);
    check("reset_top", top_out, 8'h00);
    check("reset_halted", halted, 1'b0);
    check("reset_state", dbg_state, ST_FETCH);

    // table: two pushes then one op, zero-wait ack
    vecs[0] = '{12'h005, 12'h003, 12'h400, 8'h08, 8'h01, 8'h08, 7};
    vecs[1] = '{12'h003, 12'h005, 12'h500, 8'hFE, 8'h01, 8'hFE, 7};
    vecs[2] = '{12'h014, 12'h00D, 12'h600, 8'h04, 8'h01, 8'h04, 7};
    vecs[3] = '{12'h0FF, 12'h002, 12'h4AB, 8'h01, 8'h01, 8'h01, 7};
    vecs[4] = '{12'h000, 12'h001, 12'h500, 8'hFF, 8'h01, 8'hFF, 7};
    vecs[5] = '{12'h010, 12'h010, 12'h600, 8'h00, 8'h01, 8'h00, 7};
    vecs[6] = '{12'h007, 12'h009, 12'h3C4, 8'h09, 8'h02, 8'h09, 6};
    for (int v = 0; v < 7; v++) begin
      imem[0] = vecs[v].i0; imem[1] = vecs[v].i1; imem[2] = vecs[v].i2; imem[3] = 12'h800;
      do_reset();
      run = 1'b1;
      run_until_pc(8'h03, 40, cyc);
      run = 1'b0;
      check($sformatf("vec%0d_cycles", v), cyc, vecs[v].cycles);
      check($sformatf("vec%0d_top", v), top_out, vecs[v].top);
      check($sformatf("vec%0d_sp", v), sp_out, vecs[v].sp);
      check($sformatf("vec%0d_ram_at_sp", v), ram[vecs[v].sp], vecs[v].ram_sp);
    end

    // delayed ack with run dropped mid-wait: request held, single execution
    imem[0] = 12'h05A; imem[1] = 12'h800;
    do_reset();
    ack_delay = 3;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) run = 1'b0;
      check($sformatf("wait_req_c%0d", i), last_req, 1'b1);
      check($sformatf("wait_addr_c%0d", i), last_addr, 8'h00);
    end
    for (int i = 0; i < 6; i++) tick();
    check("wait_pc", pc_out, 8'h01);
    check("wait_sp", sp_out, 8'h01);
    check("wait_top", top_out, 8'h5A);
    check("wait_ram1", ram[1], 8'h5A);
    check("wait_writes", we_cnt, 1);
    check("stall_req_cnt", req_cnt, 4);
    check("stall_state", dbg_state, ST_FETCH);

    // spurious ack while idle is ignored; next real fetch gets the HALT at pc 1
    ack_delay = 0; we_cnt = 0;
    spur_ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    spur_ack = 1'b0;
    check("spur_pc", pc_out, 8'h01);
    check("spur_state", dbg_state, ST_FETCH);
    check("spur_writes", we_cnt, 0);
    run = 1'b1;
    run_until_halted(20, 1'b0, cyc);
    check("spur_top_kept", top_out, 8'h5A);
    check("spur_halt_pc", pc_out, 8'h01);

    // HALT at pc 5, then stay silent for 20 cycles
    imem[0] = 12'h1FF; imem[1] = 12'h234; imem[2] = 12'h700; imem[3] = 12'h9AA;
    imem[4] = 12'hF00; imem[5] = 12'h800;
    do_reset();
    run = 1'b1;
    run_until_halted(100, 1'b0, cyc);
    check("halt_cycles", cyc, 12);
    check("halt_flag", halted, 1'b1);
    check("halt_pc", pc_out, 8'h05);
    check("halt_state", dbg_state, ST_HALT);
    req_cnt = 0; we_cnt = 0;
    for (int i = 0; i < 20; i++) tick();
    check("halt_no_req", req_cnt, 0);
    check("halt_no_we", we_cnt, 0);
    check("halt_pc_held", pc_out, 8'h05);
    check("halt_flag_held", halted, 1'b1);

    // binary op at sp=0 wraps to address FF
    imem[0] = 12'h003; imem[1] = 12'h400; imem[2] = 12'h400; imem[3] = 12'h800;
    do_reset();
    r0 = ram[0]; rff = ram[8'hFF];
    v1 = r0 + 8'h03;
    v2 = rff + v1;
    exp_q.delete();
    exp_q.push_back({8'h01, 8'h03});
    exp_q.push_back({8'h00, v1});
    exp_q.push_back({8'hFF, v2});
    sb_on = 1'b1;
    run = 1'b1;
    run_until_halted(60, 1'b0, cyc);
    sb_on = 1'b0;
    check("wrap_cycles", cyc, 10);
    check("wrap_sp", sp_out, 8'hFF);
    check("wrap_top", top_out, v2);
    check("wrap_ramff", ram[8'hFF], v2);
    check("wrap_sb_drain", exp_q.size(), 0);

    // RESET during WB suppresses the write and restarts cleanly
    imem[0] = 12'h005; imem[1] = 12'h003; imem[2] = 12'h400; imem[3] = 12'h800;
    do_reset();
    run = 1'b1;
    cyc = 0;
    while (dbg_state !== ST_WB && cyc < 20) begin
      tick();
      cyc++;
    end
    check_true("wbrst_reached_wb", dbg_state === ST_WB);
    RESET = 1'b1;
    #1;
    check("wbrst_we", ram_we, 1'b0);
    check("wbrst_req", imem_req, 1'b0);
    tick();
    check("wbrst_pc", pc_out, 8'h00);
    check("wbrst_sp", sp_out, SP_INIT);
    check("wbrst_top", top_out, 8'h00);
    check("wbrst_state", dbg_state, ST_FETCH);
    check("wbrst_ram1", ram[1], 8'h05);
    check("wbrst_ram2", ram[2], 8'h03);
    RESET = 1'b0; run = 1'b0;

    // random programs, random ack delay and run gaps, checked against the model
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 24; k++) begin
        int r;
        logic [3:0] op;
        r = int'($urandom_range(0, 15));
        if (r < 6)       op = 4'h0;
        else if (r < 8)  op = 4'h4;
        else if (r < 10) op = 4'h5;
        else if (r < 12) op = 4'h6;
        else if (r < 14) op = 4'($urandom_range(9, 15));
        else if (r < 15) op = 4'($urandom_range(1, 3));
        else             op = 4'h7;
        imem[k] = {op, 8'($urandom)};
      end
      imem[24] = 12'h800;
      do_reset();
      for (int i = 0; i < 256; i++) model_mem[i] = ram[i];
      exp_q.delete();
      model_run();
      sb_on = 1'b1; rand_delay = 1'b1;
      run_until_halted(3000, 1'b1, cyc);
      sb_on = 1'b0; rand_delay = 1'b0; run = 1'b0;
      check($sformatf("rnd%0d_pc", it), pc_out, m_pc);
      check($sformatf("rnd%0d_sp", it), sp_out, m_sp);
      check($sformatf("rnd%0d_top", it), top_out, m_top);
      check($sformatf("rnd%0d_sb_drain", it), exp_q.size(), 0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (ram[i] !== model_mem[i]) bad++;
      check($sformatf("rnd%0d_ram_image_bad_words", it), bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
